// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared types and helpers for the iterative divider
package div_sequencer_pkg;

    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);
    logic [33:0] shifted;
    logic        ge;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[31]};
        ge      = (shifted >= {2'b00, dvs_i});
        // Only taken when ge, so the 33-bit difference cannot wrap.
        diff    = shifted[32:0] - {1'b0, dvs_i};
        rem_o   = ge ? diff : shifted[32:0];
        quo_o   = {quo_i[30:0], ge};
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M DIV/DIVU/REM/REMU sequencer with pipeline stall
module div_sequencer
    import div_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  div_op_t     op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    div_op_t     op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic [32:0] step_rem;
    logic [31:0] step_quo;
    logic        req_signed;
    logic        req_ovf;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        req_signed = ~op[0];
        req_ovf    = req_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        fix_quo    = neg_quo_q ? (~step_quo + 32'd1) : step_quo;
        fix_rem    = neg_rem_q ? (~step_rem[31:0] + 32'd1) : step_rem[31:0];

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    rd_d      = rd_in;
                    neg_quo_d = req_signed && (dividend[31] ^ divisor[31]);
                    neg_rem_d = req_signed && dividend[31];
                    dvs_d     = mag32(divisor, req_signed);
                    quo_d     = mag32(dividend, req_signed);
                    rem_d     = '0;
                    cnt_d     = '0;
                    // Special cases skip the iterations and present their result next cycle.
                    if (divisor == '0) begin
                        state_d  = DONE;
                        result_d = op[1] ? dividend : 32'hFFFF_FFFF;
                        rd_out_d = rd_in;
                    end else if (req_ovf) begin
                        state_d  = DONE;
                        result_d = op[1] ? 32'h0 : 32'h8000_0000;
                        rd_out_d = rd_in;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_STEPS - 1)) begin
                    state_d  = DONE;
                    result_d = op_q[1] ? fix_rem : fix_quo;
                    rd_out_d = rd_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush must leave the visible result untouched, even on the final step.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= DIV;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign busy   = (state_q != IDLE);
    assign valid  = (state_q == DONE) && !flush;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    div_op_t     op = DIVU;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall, busy, valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    div_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .rd_in    (rd_in),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .valid    (valid),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_div(input div_op_t o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic special);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        special = 1'b1;
        if (b == 0)
            r = (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : a;
        else if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = (o == DIV) ? 32'h8000_0000 : 32'h0;
        else begin
            special = 1'b0;
            case (o)
                DIV:     r = sa / sb;
                REM:     r = sa % sb;
                DIVU:    r = a / b;
                default: r = a % b;
            endcase
        end
    endtask

    // Abstract model: pending flag plus cycles remaining until the valid cycle.
    logic        m_pend = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_nres = '0;
    logic [4:0]  m_rd = '0, m_nrd = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] r;
        logic        sp;
        if (!rst_n) begin
            m_pend = 1'b0; m_left = 0; m_res = '0; m_rd = '0;
        end else if (flush) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (m_left == 0) m_pend = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) begin m_res = m_nres; m_rd = m_nrd; end
            end
        end else if (start) begin
            ref_div(op, dividend, divisor, r, sp);
            m_pend = 1'b1; m_nres = r; m_nrd = rd_in;
            if (sp) begin m_left = 0; m_res = r; m_rd = rd_in; end
            else m_left = 32;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_pend));
        chk("valid", 32'(valid), 32'(m_pend && m_left == 0 && !flush));
        chk("stall", 32'(stall), 32'((!m_pend && start && !flush) || (m_pend && m_left > 0)));
        chk("result", result, m_res);
        chk("rd_out", 32'(rd_out), 32'(m_rd));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input div_op_t o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        step();
        start = 1'b1; op = o; dividend = a; divisor = b; rd_in = r;
        step();
        start = 1'b0; op = div_op_t'($urandom_range(0, 3));
        dividend = $urandom; divisor = $urandom; rd_in = 5'($urandom);
    endtask

    task automatic wait_valid(input string name, input logic lit, input int exp_lat,
                              input logic [31:0] exp_res, input logic [4:0] exp_rd);
        int   n;
        logic got;
        n = 1; got = 1'b0;
        while (n <= 40 && !got) begin
            @(negedge clk);
            if (valid) got = 1'b1;
            else begin step(); n++; end
        end
        chk({name, "_seen"}, 32'(got), 32'd1);
        if (lit && got) begin
            chk({name, "_lat"}, n, exp_lat);
            chk({name, "_res"}, result, exp_res);
            chk({name, "_rd"}, 32'(rd_out), 32'(exp_rd));
        end
    endtask

    initial begin
        int vcount;
        logic [31:0] a, b;
        div_op_t o;
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        issue(DIVU, 32'd100, 32'd7, 5'd11);       wait_valid("divu_100_7", 1, 33, 32'h0000_000E, 5'd11);
        issue(REMU, 32'd100, 32'd7, 5'd12);       wait_valid("remu_100_7", 1, 33, 32'd2, 5'd12);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);   wait_valid("div_m7_2", 1, 33, 32'hFFFF_FFFD, 5'd3);
        issue(REM, 32'hFFFF_FFF9, 32'd2, 5'd4);   wait_valid("rem_m7_2", 1, 33, 32'hFFFF_FFFF, 5'd4);
        issue(REM, 32'd7, 32'hFFFF_FFFE, 5'd5);   wait_valid("rem_7_m2", 1, 33, 32'd1, 5'd5);
        issue(DIVU, 32'd5, 32'd0, 5'd6);          wait_valid("divu_5_0", 1, 1, 32'hFFFF_FFFF, 5'd6);
        issue(REM, 32'hFFFF_FFFB, 32'd0, 5'd7);   wait_valid("rem_m5_0", 1, 1, 32'hFFFF_FFFB, 5'd7);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8); wait_valid("div_ovf", 1, 1, 32'h8000_0000, 5'd8);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_valid("rem_ovf", 1, 1, 32'h0, 5'd9);

        // Flush in cycle 10 of CALC, restart in cycle 12.
        issue(DIVU, 32'd100, 32'd7, 5'd20);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk); chk("flush_idle", 32'(busy), 32'd0);
        issue(DIVU, 32'd9, 32'd3, 5'd21);         wait_valid("after_flush", 1, 33, 32'd3, 5'd21);

        // Reset during CALC with an ignored start while busy.
        issue(DIVU, 32'hDEAD_BEEF, 32'd13, 5'd22);
        repeat (4) step();
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd23;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_result", result, 32'h0);
        chk("arst_rd", 32'(rd_out), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin @(negedge clk); if (valid) vcount++; step(); end
        chk("no_valid_after_reset", vcount, 0);

        // start together with flush in IDLE is dropped.
        start = 1'b1; flush = 1'b1; dividend = 32'd8; divisor = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        @(negedge clk); chk("start_flush_dropped", 32'(busy), 32'd0);

        for (int i = 0; i < 30; i++) begin
            o = div_op_t'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                3: begin a = -$urandom_range(0, 1000); b = -$urandom_range(1, 20); end
                4: b = $urandom_range(1, 3);
                default: ;
            endcase
            issue(o, a, b, 5'($urandom));
            wait_valid("random", 0, 0, 32'h0, 5'd0);
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
